voice_mix_i2s: RTL and testbench
================================

Name: voice_mix_i2s

Overview:
Downstream stage of the voice array. Sums the signed 16-bit outputs of NUM_VOICES voices, scales the sum with saturation, and streams the result as mono (same sample on left and right) I2S data to the board audio codec DAC. Also generates the frame-rate sample_req strobe that advances the voices, so the codec frame clock paces the whole synth.

Parameters:
NUM_VOICES, 4, number of 16-bit voice inputs summed
GAIN_SHIFT, 2, arithmetic right shift applied to the full-width sum before saturation (0..clog2(NUM_VOICES))
BCLK_DIV, 4, Clk cycles per BCLK half-period (>=2)

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-low reset
voices_in  input  16*NUM_VOICES  packed signed voice samples, voice k at [16k+15:16k]
enable  input  1  1 = stream mix, 0 = stream zero samples (clocks keep running)
clip_clr  input  1  synchronous clear of clip
BCLK  output  1  codec bit clock
LRCLK  output  1  codec frame clock, 0 = left slot, 1 = right slot
DACDAT  output  1  serial data, MSB first
sample_req  output  1  one-Clk pulse at every frame start
clip  output  1  sticky: saturation occurred
mix_out  output  16  current registered mix sample (for monitoring/LEDs)

Behaviour:
- Reset (Reset=0, async): BCLK=0, LRCLK=0, DACDAT=0, sample_req=0, clip=0, mix_out=0, div_cnt=0, bit_cnt=63, shift registers=0.
- Mix path, 1 Clk latency: sum = signed sum of all voices at width 16+clog2(NUM_VOICES); s = sum >>> GAIN_SHIFT; mix_out <= s clamped to [-32768, 32767]. If enable=0, mix_out <= 0. Clamp sets clip=1 in the same cycle. clip_clr=1 clears clip; a clamp in the same cycle wins (clip stays 1).
- Clock divider: div_cnt counts 0..BCLK_DIV-1. When div_cnt==BCLK_DIV-1, it wraps to 0 and BCLK toggles. BCLK period = 2*BCLK_DIV Clk cycles. First rising edge is BCLK_DIV cycles after reset release.
- Falling edge (cycle in which BCLK toggles 1->0):
  - bit_cnt <= (bit_cnt+1) mod 64.
  - LRCLK <= (new bit_cnt >= 32).
  - Slot position p = new bit_cnt mod 32.
  - DACDAT: p==0 -> 0; p=1..16 -> sample bit (16-p), MSB first; p=17..31 -> 0. This is I2S one-BCLK delay with a 32-bit slot.
- Frame start is the falling edge where bit_cnt goes 63->0. In that same Clk cycle:
  - both left and right shift registers load mix_out (value present before the edge);
  - sample_req=1 for exactly one Clk cycle.
  - The first falling edge after reset is a frame start.
- Right slot transmits the copy latched at frame start, never a newer mix_out.
- Outputs change only on falling-edge cycles (except mix_out and clip); the codec samples on BCLK rising.
- Frame period = 64*2*BCLK_DIV Clk cycles (512 at default).
- Changing enable mid-frame affects only the next frame's latch.
- Reset mid-frame: all state returns to reset values immediately. The partial frame is abandoned and the next frame starts at the first falling edge.

Test Plan:
- Reset release, BCLK_DIV=4: BCLK rises at cycle 4, falls at 8. sample_req pulses at cycle 8 and then every 512 cycles. LRCLK low for 32 BCLKs, then high for 32.
- All voices=16'h1000, GAIN_SHIFT=2: mix_out=16'h1000 one cycle later. Left and right slots each shift 0,0001000000000000, then 15 zeros; clip stays 0.
- All voices=16'h7FFF, GAIN_SHIFT=0: mix_out=16'h7FFF and clip=1. With all 16'h8000: mix_out=16'h8000. clip_clr pulse with non-saturating inputs clears clip.
- voices = 16'h1234 (v0) and zeros (others), GAIN_SHIFT=0: mix_out changed to 16'h4321 during the left slot. Right slot still sends 16'h1234; the next frame sends 16'h4321.
- enable=0 with non-zero voices: mix_out=0, DACDAT=0 for the next full frame; BCLK, LRCLK and sample_req keep running.
- Assert Reset at bit_cnt=40: outputs go to reset values asynchronously. After release, a frame start occurs at cycle 8 with LRCLK=0.

Source files
------------

// File: rtl/voice_mix_i2s.sv
// Voice mixer with mono I2S transmitter.
// Sums NUM_VOICES signed 16-bit voices, scales by an arithmetic right shift,
// saturates to 16 bits, and streams the latched sample on both I2S slots.
// The frame start also emits sample_req, which advances the voice array.
module voice_mix_i2s #(
    parameter int NUM_VOICES = 4,
    parameter int GAIN_SHIFT = 2,
    parameter int BCLK_DIV   = 4
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [16*NUM_VOICES-1:0]  voices_in,
    input  logic                      enable,
    input  logic                      clip_clr,
    output logic                      BCLK,
    output logic                      LRCLK,
    output logic                      DACDAT,
    output logic                      sample_req,
    output logic                      clip,
    output logic [15:0]               mix_out
);

    // The sum width grows by clog2(NUM_VOICES) bits, so the sum cannot overflow.
    localparam int SUM_W = 16 + $clog2(NUM_VOICES);
    localparam int DIV_W = $clog2(BCLK_DIV);

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-32768);
    localparam logic [DIV_W-1:0]        DIV_TOP = DIV_W'(BCLK_DIV - 1);

    logic signed [SUM_W-1:0] voice_ext [NUM_VOICES];
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] scaled;
    logic [15:0]             mix_sat;
    logic                    clamp_hit;

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [5:0]       bit_next;
    logic [4:0]       slot_pos;
    logic             div_tick;
    logic             bclk_fall;
    logic             frame_start;
    logic [15:0]      left_shift;
    logic [15:0]      right_shift;

    // Sign-extend each voice to the full sum width.
    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_ext
            assign voice_ext[gi] = SUM_W'($signed(voices_in[16*gi +: 16]));
        end
    endgenerate

    // Full-width sum, gain shift, and saturation to the 16-bit range.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            sum = sum + voice_ext[i];
        end
        scaled    = sum >>> GAIN_SHIFT;
        clamp_hit = 1'b0;
        mix_sat   = scaled[15:0];
        if (scaled > SAT_MAX) begin
            mix_sat   = 16'h7FFF;
            clamp_hit = 1'b1;
        end else if (scaled < SAT_MIN) begin
            mix_sat   = 16'h8000;
            clamp_hit = 1'b1;
        end
    end

    // Registered mix sample and sticky clip flag; a clamp outranks a clear.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mix_out <= '0;
            clip    <= 1'b0;
        end else begin
            mix_out <= enable ? mix_sat : 16'h0000;
            if (enable && clamp_hit) begin
                clip <= 1'b1;
            end else if (clip_clr) begin
                clip <= 1'b0;
            end
        end
    end

    assign div_tick    = (div_cnt == DIV_TOP);
    assign bclk_fall   = div_tick && BCLK;
    assign bit_next    = bit_cnt + 6'd1;
    assign slot_pos    = bit_next[4:0];
    assign frame_start = bclk_fall && (bit_next == 6'd0);

    // Bit-clock divider: BCLK toggles every BCLK_DIV system clocks.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div_cnt <= '0;
            BCLK    <= 1'b0;
        end else if (div_tick) begin
            div_cnt <= '0;
            BCLK    <= ~BCLK;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Serializer: all codec-facing outputs update on BCLK falling edges only.
    // Each 32-bit slot sends one idle bit, 16 data bits MSB first, then zeros.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bit_cnt     <= 6'd63;
            LRCLK       <= 1'b0;
            DACDAT      <= 1'b0;
            sample_req  <= 1'b0;
            left_shift  <= '0;
            right_shift <= '0;
        end else begin
            sample_req <= frame_start;
            if (bclk_fall) begin
                bit_cnt <= bit_next;
                LRCLK   <= bit_next[5];
                if (frame_start) begin
                    left_shift  <= mix_out;
                    right_shift <= mix_out;
                    DACDAT      <= 1'b0;
                end else if (slot_pos >= 5'd1 && slot_pos <= 5'd16) begin
                    if (bit_next[5]) begin
                        DACDAT      <= right_shift[15];
                        right_shift <= {right_shift[14:0], 1'b0};
                    end else begin
                        DACDAT     <= left_shift[15];
                        left_shift <= {left_shift[14:0], 1'b0};
                    end
                end else begin
                    DACDAT <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_mix_i2s.sv
// Directed bench for voice_mix_i2s: two instances share stimulus, one with
// GAIN_SHIFT=2 (default) and one with GAIN_SHIFT=0 for saturation cases.
module tb_voice_mix_i2s;

    logic        Clk;
    logic        Reset;
    logic [63:0] voices_in;
    logic        enable;
    logic        clip_clr;

    logic        bclk_g2, lrclk_g2, dac_g2, sreq_g2, clip_g2;
    logic [15:0] mix_g2;
    logic        bclk_g0, lrclk_g0, dac_g0, sreq_g0, clip_g0;
    logic [15:0] mix_g0;

    int n_cmp = 0;
    int n_bad = 0;

    voice_mix_i2s #(.NUM_VOICES(4), .GAIN_SHIFT(2), .BCLK_DIV(4)) u_g2 (
        .Clk(Clk), .Reset(Reset), .voices_in(voices_in), .enable(enable),
        .clip_clr(clip_clr), .BCLK(bclk_g2), .LRCLK(lrclk_g2), .DACDAT(dac_g2),
        .sample_req(sreq_g2), .clip(clip_g2), .mix_out(mix_g2)
    );

    voice_mix_i2s #(.NUM_VOICES(4), .GAIN_SHIFT(0), .BCLK_DIV(4)) u_g0 (
        .Clk(Clk), .Reset(Reset), .voices_in(voices_in), .enable(enable),
        .clip_clr(clip_clr), .BCLK(bclk_g0), .LRCLK(lrclk_g0), .DACDAT(dac_g0),
        .sample_req(sreq_g0), .clip(clip_g0), .mix_out(mix_g0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Advance until BCLK goes 0->1 (codec sampling point), bounded.
    task automatic wait_bclk_rise(output logic ok);
        logic prev;
        prev = bclk_g2;
        ok   = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (!prev && bclk_g2) begin
                ok = 1'b1;
                break;
            end
            prev = bclk_g2;
        end
    endtask

    // Wait for the next frame start, then sample 64 bits at BCLK rising edges.
    // frame[63-i] holds the bit seen at slot position i. Optionally changes the
    // voice inputs after sampling bit index chg_at.
    task automatic capture(input string tag, input int chg_at, input logic [63:0] chg_val,
                           output logic [63:0] f0, output logic [63:0] f2,
                           output logic [63:0] lr);
        logic got;
        logic ok;
        logic all_ok;
        got = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            tick();
            if (sreq_g2) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_sreq_seen"}, {63'd0, got}, 64'd1);
        f0 = '0;
        f2 = '0;
        lr = '0;
        all_ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            wait_bclk_rise(ok);
            all_ok = all_ok & ok;
            f0[63-i] = dac_g0;
            f2[63-i] = dac_g2;
            lr[63-i] = lrclk_g2;
            if (i == chg_at) voices_in = chg_val;
        end
        check({tag, "_bclk_run"}, {63'd0, all_ok}, 64'd1);
        $display("frame %s: g0=%h g2=%h lr=%h", tag, f0, f2, lr);
    endtask

    function automatic logic [63:0] frame_of(input logic [15:0] s);
        return {1'b0, s, 15'd0, 1'b0, s, 15'd0};
    endfunction

    localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

    initial begin
        logic [63:0] f0, f2, lr;
        int n;

        Reset     = 1'b0;
        voices_in = '0;
        enable    = 1'b1;
        clip_clr  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_bclk",   {63'd0, bclk_g2},  64'd0);
        check("rst_lrclk",  {63'd0, lrclk_g2}, 64'd0);
        check("rst_dacdat", {63'd0, dac_g2},   64'd0);
        check("rst_sreq",   {63'd0, sreq_g2},  64'd0);
        check("rst_clip",   {63'd0, clip_g0},  64'd0);
        check("rst_mix",    {48'd0, mix_g2},   64'd0);

        // Release just after an edge; following edges are cycles 1, 2, ...
        Reset = 1'b1;
        tick(); tick(); tick();
        check("c3_bclk", {63'd0, bclk_g2}, 64'd0);
        tick();
        check("c4_bclk_rise", {63'd0, bclk_g2}, 64'd1);
        tick(); tick(); tick();
        check("c7_sreq", {63'd0, sreq_g2}, 64'd0);
        tick();
        check("c8_bclk_fall", {63'd0, bclk_g2},  64'd0);
        check("c8_sreq",      {63'd0, sreq_g2},  64'd1);
        check("c8_lrclk",     {63'd0, lrclk_g2}, 64'd0);
        tick();
        check("c9_sreq_drop", {63'd0, sreq_g2}, 64'd0);
        n = 1;
        while (!sreq_g2 && n < 600) begin
            tick();
            n++;
        end
        check("frame_period", 64'(n), 64'd512);

        // All voices 0x1000
        voices_in = {4{16'h1000}};
        tick();
        check("mix_1000_g2", {48'd0, mix_g2}, 64'h1000);
        check("mix_1000_g0", {48'd0, mix_g0}, 64'h4000);
        capture("f1000", -1, '0, f0, f2, lr);
        check("frame_1000_g2", f2, frame_of(16'h1000));
        check("lrclk_frame",   lr, LR_EXP);
        check("clip_1000_g2",  {63'd0, clip_g2}, 64'd0);
        check("clip_1000_g0",  {63'd0, clip_g0}, 64'd0);

        // Saturation and sticky clip
        voices_in = {4{16'h7FFF}};
        tick();
        check("mix_7fff_g0",  {48'd0, mix_g0}, 64'h7FFF);
        check("clip_7fff_g0", {63'd0, clip_g0}, 64'd1);
        check("mix_7fff_g2",  {48'd0, mix_g2}, 64'h7FFF);
        check("clip_7fff_g2", {63'd0, clip_g2}, 64'd0);
        voices_in = {4{16'h8000}};
        tick();
        check("mix_8000_g0",  {48'd0, mix_g0}, 64'h8000);
        check("mix_8000_g2",  {48'd0, mix_g2}, 64'h8000);
        check("clip_sticky",  {63'd0, clip_g0}, 64'd1);
        voices_in = {4{16'h0100}};
        clip_clr  = 1'b1;
        tick();
        check("clip_cleared", {63'd0, clip_g0}, 64'd0);
        check("mix_0100_g0",  {48'd0, mix_g0}, 64'h0400);
        voices_in = {4{16'h7FFF}};
        tick();
        check("clip_clamp_wins", {63'd0, clip_g0}, 64'd1);
        voices_in = {4{16'h0100}};
        tick();
        clip_clr = 1'b0;
        check("clip_cleared2", {63'd0, clip_g0}, 64'd0);

        // Right slot keeps the frame-start copy when mix_out changes mid-frame
        voices_in = {48'd0, 16'h1234};
        capture("f1234", 8, {48'd0, 16'h4321}, f0, f2, lr);
        check("frame_1234_g0", f0, frame_of(16'h1234));
        check("mix_4321_g0", {48'd0, mix_g0}, 64'h4321);
        capture("f4321", -1, '0, f0, f2, lr);
        check("frame_4321_g0", f0, frame_of(16'h4321));
        check("frame_4321_g2", f2, frame_of(16'h10C8));

        // enable=0 streams zeros but clocks and sample_req keep running
        enable = 1'b0;
        tick();
        check("mix_dis_g0", {48'd0, mix_g0}, 64'd0);
        check("mix_dis_g2", {48'd0, mix_g2}, 64'd0);
        capture("fdis", -1, '0, f0, f2, lr);
        check("frame_dis_g0", f0, 64'd0);
        check("frame_dis_g2", f2, 64'd0);
        check("lrclk_dis",    lr, LR_EXP);
        enable = 1'b1;

        // Mid-frame reset around bit_cnt=40
        n = 0;
        while (!sreq_g2 && n < 1100) begin
            tick();
            n++;
        end
        check("pre_rst_sreq", {63'd0, sreq_g2}, 64'd1);
        for (int i = 0; i < 41; i++) begin
            logic ok;
            wait_bclk_rise(ok);
        end
        check("pre_rst_lrclk", {63'd0, lrclk_g2}, 64'd1);
        check("pre_rst_mix",   {48'd0, mix_g0}, 64'h4321);
        Reset = 1'b0;
        #2;
        check("arst_bclk",   {63'd0, bclk_g2},  64'd0);
        check("arst_lrclk",  {63'd0, lrclk_g2}, 64'd0);
        check("arst_dacdat", {63'd0, dac_g0},   64'd0);
        check("arst_mix",    {48'd0, mix_g0},   64'd0);
        tick(); tick();
        Reset = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("rr_c7_sreq", {63'd0, sreq_g2}, 64'd0);
        tick();
        check("rr_c8_sreq",  {63'd0, sreq_g2},  64'd1);
        check("rr_c8_lrclk", {63'd0, lrclk_g2}, 64'd0);
        check("rr_c8_bclk",  {63'd0, bclk_g2},  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
